// File: rtl/traffic_pkg.sv
// Shared types, lamp encodings and default intervals for the traffic light controller.
package traffic_pkg;

    localparam int unsigned CNT_W = 4;

    // Default interval lengths, in ticks
    localparam int unsigned T_BASE_DFLT = 6;
    localparam int unsigned T_EXT_DFLT  = 3;
    localparam int unsigned T_YEL_DFLT  = 2;

    typedef enum logic [2:0] {
        MAIN_G1 = 3'd0,
        MAIN_G2 = 3'd1,
        MAIN_Y  = 3'd2,
        WALK    = 3'd3,
        SIDE_G1 = 3'd4,
        SIDE_G2 = 3'd5,
        SIDE_Y  = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        SEL_BASE = 2'd0,
        SEL_EXT  = 2'd1,
        SEL_YEL  = 2'd2,
        SEL_NONE = 2'd3
    } sel_e;

    // Lamp encodings {R,Y,G}
    localparam logic [2:0] LIGHT_R = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_G = 3'b001;

    // Main street lamp for a given state
    function automatic logic [2:0] main_lamp(state_e s);
        logic [2:0] l;
        case (s)
            MAIN_G1, MAIN_G2: l = LIGHT_G;
            MAIN_Y:           l = LIGHT_Y;
            default:          l = LIGHT_R;
        endcase
        return l;
    endfunction

    // Side street lamp for a given state
    function automatic logic [2:0] side_lamp(state_e s);
        logic [2:0] l;
        case (s)
            SIDE_G1, SIDE_G2: l = LIGHT_G;
            SIDE_Y:           l = LIGHT_Y;
            default:          l = LIGHT_R;
        endcase
        return l;
    endfunction

    // A zero-length interval would never expire, so it is stored as one tick
    function automatic logic [CNT_W-1:0] sat_interval(logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

endpackage

// File: rtl/interval_timer.sv
// Down-counter measuring the length of the current state in ticks.
module interval_timer
    import traffic_pkg::*;
#(
    parameter int unsigned RST_VAL = T_BASE_DFLT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             tick,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load has priority; otherwise count down on each tick, holding at one
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (tick && (cnt_q > CNT_W'(1))) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= CNT_W'(RST_VAL);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Last tick of the interval
    assign expire = tick && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/traffic_fsm.sv
// Traffic light controller: main/side street phases, walk phase, programmable intervals.
module traffic_fsm
    import traffic_pkg::*;
#(
    parameter int unsigned T_BASE_DEF = T_BASE_DFLT,
    parameter int unsigned T_EXT_DEF  = T_EXT_DFLT,
    parameter int unsigned T_YEL_DEF  = T_YEL_DFLT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       sensor_sync,
    input  logic       wr_sync,
    input  logic       prog_sync,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk_lamp
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] t_base_q, t_base_d;
    logic [CNT_W-1:0] t_ext_q, t_ext_d;
    logic [CNT_W-1:0] t_yel_q, t_yel_d;
    logic             walk_pend_q, walk_pend_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_expire;

    interval_timer #(
        .RST_VAL(T_BASE_DEF)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (tmr_load),
        .load_value(tmr_val),
        .tick      (tick),
        .expire    (tmr_expire)
    );

    // Interval register update from the reprogram strobe
    always_comb begin
        t_base_d = t_base_q;
        t_ext_d  = t_ext_q;
        t_yel_d  = t_yel_q;
        if (prog_sync) begin
            case (sel_e'(time_param_sel))
                SEL_BASE: t_base_d = sat_interval(time_value);
                SEL_EXT:  t_ext_d  = sat_interval(time_value);
                SEL_YEL:  t_yel_d  = sat_interval(time_value);
                default:  ;
            endcase
        end
    end

    // Next state and timer reload; reprogramming restarts the cycle at MAIN_G1
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = t_base_q;
        if (prog_sync) begin
            state_d  = MAIN_G1;
            tmr_load = 1'b1;
            tmr_val  = t_base_d;
        end else if (tmr_expire) begin
            tmr_load = 1'b1;
            case (state_q)
                MAIN_G1: begin
                    state_d = MAIN_G2;
                    tmr_val = sensor_sync ? t_ext_q : t_base_q;
                end
                MAIN_G2: begin
                    state_d = MAIN_Y;
                    tmr_val = t_yel_q;
                end
                MAIN_Y: begin
                    state_d = walk_pend_q ? WALK : SIDE_G1;
                    tmr_val = walk_pend_q ? t_ext_q : t_base_q;
                end
                WALK: begin
                    state_d = SIDE_G1;
                    tmr_val = t_base_q;
                end
                SIDE_G1: begin
                    state_d = sensor_sync ? SIDE_G2 : SIDE_Y;
                    tmr_val = sensor_sync ? t_ext_q : t_yel_q;
                end
                SIDE_G2: begin
                    state_d = SIDE_Y;
                    tmr_val = t_yel_q;
                end
                SIDE_Y: begin
                    state_d = MAIN_G1;
                    tmr_val = t_base_q;
                end
                default: begin
                    state_d = MAIN_G1;
                    tmr_val = t_base_q;
                end
            endcase
        end
    end

    // Walk request latch; entering WALK serves it and beats a same-cycle request
    always_comb begin
        walk_pend_d = walk_pend_q | wr_sync;
        if ((state_d == WALK) && (state_q != WALK)) begin
            walk_pend_d = 1'b0;
        end
    end

    // State, intervals and walk request registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= MAIN_G1;
            t_base_q    <= CNT_W'(T_BASE_DEF);
            t_ext_q     <= CNT_W'(T_EXT_DEF);
            t_yel_q     <= CNT_W'(T_YEL_DEF);
            walk_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_base_q    <= t_base_d;
            t_ext_q     <= t_ext_d;
            t_yel_q     <= t_yel_d;
            walk_pend_q <= walk_pend_d;
        end
    end

    // Lamp registers decoded from next state, so they track the state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_light <= LIGHT_G;
            side_light <= LIGHT_R;
            walk_lamp  <= 1'b0;
        end else begin
            main_light <= main_lamp(state_d);
            side_light <= side_lamp(state_d);
            walk_lamp  <= (state_d == WALK);
        end
    end

endmodule

// File: tb/tb_traffic_fsm.sv
// Scoreboard bench: expected lamp phases (pattern, length in ticks) are queued per scenario
// and compared as each observed phase closes.
module tb_traffic_fsm;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       sensor_sync;
    logic       wr_sync;
    logic       prog_sync;
    logic [1:0] time_param_sel;
    logic [3:0] time_value;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk_lamp;

    traffic_fsm dut (
        .clk           (clk),
        .reset         (reset),
        .tick          (tick),
        .sensor_sync   (sensor_sync),
        .wr_sync       (wr_sync),
        .prog_sync     (prog_sync),
        .time_param_sel(time_param_sel),
        .time_value    (time_value),
        .main_light    (main_light),
        .side_light    (side_light),
        .walk_lamp     (walk_lamp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lamp patterns {main, side, walk}
    localparam logic [6:0] P_MG = 7'b001_100_0;
    localparam logic [6:0] P_MY = 7'b010_100_0;
    localparam logic [6:0] P_SG = 7'b100_001_0;
    localparam logic [6:0] P_SY = 7'b100_010_0;
    localparam logic [6:0] P_WK = 7'b100_100_1;

    typedef struct {
        logic [6:0] pat;
        int         ticks;
    } seg_t;

    seg_t       exp_q[$];
    int         n_chk = 0;
    int         n_bad = 0;
    int         seg_idx = 0;
    logic [6:0] seg_pat;
    int         seg_len = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_seg(input logic [6:0] pat, input int ticks);
        seg_t s;
        s.pat   = pat;
        s.ticks = ticks;
        exp_q.push_back(s);
    endtask

    // Compare the phase just observed against the head of the scoreboard
    task automatic close_seg();
        seg_t e;
        if (seg_len == 0) return;
        if (exp_q.size() == 0) begin
            check($sformatf("seg%0d_underflow", seg_idx), exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("seg%0d_pat", seg_idx), int'(seg_pat), int'(e.pat));
            check($sformatf("seg%0d_len", seg_idx), seg_len, e.ticks);
        end
        seg_idx++;
        seg_len = 0;
    endtask

    // Lamps seen on a tick cycle belong to the state consuming that tick
    task automatic sample();
        logic [6:0] pat;
        pat = {main_light, side_light, walk_lamp};
        if (seg_len == 0) begin
            seg_pat = pat;
            seg_len = 1;
        end else if (pat == seg_pat) begin
            seg_len++;
        end else begin
            close_seg();
            seg_pat = pat;
            seg_len = 1;
        end
    endtask

    // One clock cycle: drive after the rising edge, observe on the falling edge
    task automatic step(input logic t, input logic s, input logic w, input logic p,
                        input logic [1:0] sel, input logic [3:0] val);
        tick           = t;
        sensor_sync    = s;
        wr_sync        = w;
        prog_sync      = p;
        time_param_sel = sel;
        time_value     = val;
        @(negedge clk);
        if (t) sample();
        @(posedge clk);
        #1;
    endtask

    // n ticks, one every third cycle
    task automatic do_ticks(input int n, input logic s);
        for (int i = 0; i < n; i++) begin
            step(1'b1, s, 1'b0, 1'b0, 2'd3, 4'd0);
            step(1'b0, s, 1'b0, 1'b0, 2'd3, 4'd0);
            step(1'b0, s, 1'b0, 1'b0, 2'd3, 4'd0);
        end
    endtask

    // Reset asserted mid-cycle; lamps must respond before the next clock edge
    task automatic do_reset(input string tag);
        tick      = 1'b0;
        wr_sync   = 1'b0;
        prog_sync = 1'b0;
        reset     = 1'b0;
        #2;
        check({tag, "_rst_main"}, int'(main_light), int'(3'b001));
        check({tag, "_rst_side"}, int'(side_light), int'(3'b100));
        check({tag, "_rst_walk"}, int'(walk_lamp), 0);
        seg_len = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic finish_scn(input string tag);
        close_seg();
        check({tag, "_sb_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        reset          = 1'b1;
        tick           = 1'b0;
        sensor_sync    = 1'b0;
        wr_sync        = 1'b0;
        prog_sync      = 1'b0;
        time_param_sel = 2'd3;
        time_value     = 4'd0;
        #3;

        // Defaults, no sensor, no walk: 22-tick cycle, twice
        do_reset("dflt");
        for (int r = 0; r < 2; r++) begin
            push_seg(P_MG, 12); push_seg(P_MY, 2); push_seg(P_SG, 6); push_seg(P_SY, 2);
        end
        do_ticks(44, 1'b0);
        finish_scn("dflt");

        // Sensor held: both greens extended to 9 ticks
        do_reset("sens");
        for (int r = 0; r < 2; r++) begin
            push_seg(P_MG, 9); push_seg(P_MY, 2); push_seg(P_SG, 9); push_seg(P_SY, 2);
        end
        do_ticks(44, 1'b1);
        finish_scn("sens");

        // One-cycle walk request in MAIN_G1: one walk phase, then normal cycle
        do_reset("walk");
        push_seg(P_MG, 12); push_seg(P_MY, 2); push_seg(P_WK, 3);
        push_seg(P_SG, 6);  push_seg(P_SY, 2);
        push_seg(P_MG, 12); push_seg(P_MY, 2); push_seg(P_SG, 6); push_seg(P_SY, 2);
        do_ticks(2, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 4'd0);
        do_ticks(45, 1'b0);
        finish_scn("walk");

        // Reprogram base=4 on a tick cycle, 4th tick of SIDE_G1
        do_reset("prog");
        push_seg(P_MG, 12); push_seg(P_MY, 2); push_seg(P_SG, 4);
        push_seg(P_MG, 8);  push_seg(P_MY, 2); push_seg(P_SG, 4); push_seg(P_SY, 2);
        do_ticks(17, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'd4);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'd0);
        do_ticks(16, 1'b0);
        finish_scn("prog");

        // Yellow=0 stored as 1, ext=5, sel=3 held across two ticks writes nothing
        do_reset("psel");
        push_seg(P_MG, 13); push_seg(P_MY, 1); push_seg(P_SG, 11); push_seg(P_SY, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'd5);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 4'd9);
            step(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 4'd9);
            step(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 4'd9);
        end
        do_ticks(24, 1'b1);
        finish_scn("psel");

        // Reset mid-MAIN_Y with a walk pending: walk request is discarded
        do_reset("mrst");
        push_seg(P_MG, 12); push_seg(P_MY, 1);
        do_ticks(2, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 4'd0);
        do_ticks(11, 1'b0);
        close_seg();
        do_reset("mrst2");
        push_seg(P_MG, 12); push_seg(P_MY, 2); push_seg(P_SG, 6); push_seg(P_SY, 2);
        do_ticks(22, 1'b0);
        finish_scn("mrst");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
